// File: rtl/lbm_step_sequencer.sv
// -----------------------------------------------------------------------------
// lbm_step_sequencer
//
// Top-level scheduler for the lattice-Boltzmann update loop. A frame runs a
// programmed number of timesteps, each made of one collision pass followed by
// one streaming pass. The block owns the 9-lane BRAM address bus and steers it
// to the active pass, or to the video reader while idle. Each pass is guarded
// by a watchdog; a hung pass ends the frame and raises a sticky error flag.
//
// Ports
//   clk_in             system clock, all logic on posedge
//   rst_in             synchronous active-high reset
//   start_in           one-cycle frame request, honoured only when idle
//   steps_in           timesteps per frame, latched on an accepted start
//   collide_start_out  one-cycle start pulse to the collision pass
//   collide_done_in    one-cycle completion pulse from the collision pass
//   collide_addr_in    collision pass address lanes (9 x BRAM_SIZE)
//   stream_start_out   one-cycle start pulse to the streaming pass
//   stream_done_in     one-cycle completion pulse from the streaming pass
//   stream_addr_in     streaming pass address lanes (9 x BRAM_SIZE)
//   video_addr_in      video read address, placed on lane 0 when granted
//   video_grant_out    high while the video reader owns the bus
//   addr_out           registered, muxed BRAM address lanes (9 x BRAM_SIZE)
//   owner_out          bus owner: 0 video, 1 collide, 2 stream
//   step_count_out     timesteps completed in the current or last frame
//   busy_out           high from start acceptance until frame end
//   done_out           one-cycle frame-complete pulse
//   error_out          sticky watchdog flag, cleared by reset or a new start
// -----------------------------------------------------------------------------
module lbm_step_sequencer #(
    parameter  int HPIXELS   = 205,
    parameter  int VPIXELS   = 154,
    parameter  int TIMEOUT   = 100000,
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [7:0]               steps_in,
    output logic                     collide_start_out,
    input  logic                     collide_done_in,
    input  logic [9*BRAM_SIZE-1:0]   collide_addr_in,
    output logic                     stream_start_out,
    input  logic                     stream_done_in,
    input  logic [9*BRAM_SIZE-1:0]   stream_addr_in,
    input  logic [BRAM_SIZE-1:0]     video_addr_in,
    output logic                     video_grant_out,
    output logic [9*BRAM_SIZE-1:0]   addr_out,
    output logic [1:0]               owner_out,
    output logic [7:0]               step_count_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     error_out
);

    localparam int LANES_W = 9 * BRAM_SIZE;
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    // Last watchdog value a WAIT state may reach before the pass is declared hung.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] OWN_VIDEO   = 2'd0;
    localparam logic [1:0] OWN_COLLIDE = 2'd1;
    localparam logic [1:0] OWN_STREAM  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        C_START,
        C_WAIT,
        S_START,
        S_WAIT,
        FINISH
    } state_t;

    state_t              r_state;
    logic [7:0]          r_steps;
    logic [7:0]          r_step_count;
    logic [WD_W-1:0]     r_wdog;
    logic                r_zero_hold;
    logic [1:0]          r_owner;
    logic                r_grant;
    logic                r_collide_start;
    logic                r_stream_start;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [LANES_W-1:0]  r_addr;

    logic                w_timeout;
    logic [7:0]          w_count_next;
    logic [LANES_W-1:0]  w_addr_next;

    assign w_timeout    = (r_wdog == WD_LAST);
    assign w_count_next = r_step_count + 8'd1;

    // Bus steering uses the owner registered last cycle, which gives addr_out
    // its one-cycle latency relative to the address inputs.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // w_addr_next unassigned, which would otherwise infer a latch.
        w_addr_next = '0;
        case (r_owner)
            OWN_VIDEO:   w_addr_next[BRAM_SIZE-1:0] = video_addr_in;
            OWN_COLLIDE: w_addr_next = collide_addr_in;
            OWN_STREAM:  w_addr_next = stream_addr_in;
            default:     w_addr_next = '0;
        endcase
    end

    // NOTE: every register below uses non-blocking assignment so all of them
    // update together from the values present before the clock edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= IDLE;
            r_steps         <= 8'd0;
            r_step_count    <= 8'd0;
            r_wdog          <= '0;
            r_zero_hold     <= 1'b0;
            r_owner         <= OWN_VIDEO;
            r_grant         <= 1'b1;
            r_collide_start <= 1'b0;
            r_stream_start  <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_addr          <= '0;
        end else begin
            r_addr          <= w_addr_next;
            // Pulse outputs fall back to low unless a transition re-asserts them.
            r_collide_start <= 1'b0;
            r_stream_start  <= 1'b0;
            r_done          <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_steps      <= steps_in;
                        r_step_count <= 8'd0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_grant      <= 1'b0;
                        if (steps_in == 8'd0) begin
                            // Empty frame spends one extra cycle in FINISH so
                            // its done pulse lands two cycles after the start.
                            r_state     <= FINISH;
                            r_zero_hold <= 1'b1;
                        end else begin
                            r_state         <= C_START;
                            r_collide_start <= 1'b1;
                            r_owner         <= OWN_COLLIDE;
                        end
                    end
                end

                C_START: begin
                    r_wdog  <= '0;
                    r_state <= C_WAIT;
                end

                C_WAIT: begin
                    // A done pulse in the timeout cycle still completes the pass.
                    if (collide_done_in) begin
                        r_state        <= S_START;
                        r_stream_start <= 1'b1;
                        r_owner        <= OWN_STREAM;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end

                S_START: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (stream_done_in) begin
                        r_step_count <= w_count_next;
                        if (w_count_next == r_steps) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= FINISH;
                        end else begin
                            r_collide_start <= 1'b1;
                            r_owner         <= OWN_COLLIDE;
                            r_state         <= C_START;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end

                FINISH: begin
                    if (r_zero_hold) begin
                        r_zero_hold <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_owner <= OWN_VIDEO;
                        r_grant <= 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign collide_start_out = r_collide_start;
    assign stream_start_out  = r_stream_start;
    assign video_grant_out   = r_grant;
    assign addr_out          = r_addr;
    assign owner_out         = r_owner;
    assign step_count_out    = r_step_count;
    assign busy_out          = r_busy;
    assign done_out          = r_done;
    assign error_out         = r_error;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lbm_step_sequencer
//
// Self-checking bench for lbm_step_sequencer with TIMEOUT=50. For every frame
// the bench first plans the whole timeline from the frame rules (start-pulse
// cycles, acknowledge cycles, watchdog expiry, frame end) using plain cycle
// arithmetic, then plays it cycle by cycle with random address data and random
// stray pulses, comparing every output against the planned timeline.
// -----------------------------------------------------------------------------
module tb_lbm_step_sequencer;

    localparam int HP  = 205;
    localparam int VP  = 154;
    localparam int TMO = 50;
    localparam int BW  = $clog2(HP * VP);
    localparam int LW  = 9 * BW;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           start_in;
    logic [7:0]     steps_in;
    logic           collide_start_out;
    logic           collide_done_in;
    logic [LW-1:0]  collide_addr_in;
    logic           stream_start_out;
    logic           stream_done_in;
    logic [LW-1:0]  stream_addr_in;
    logic [BW-1:0]  video_addr_in;
    logic           video_grant_out;
    logic [LW-1:0]  addr_out;
    logic [1:0]     owner_out;
    logic [7:0]     step_count_out;
    logic           busy_out;
    logic           done_out;
    logic           error_out;

    lbm_step_sequencer #(.HPIXELS(HP), .VPIXELS(VP), .TIMEOUT(TMO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .steps_in(steps_in),
        .collide_start_out(collide_start_out), .collide_done_in(collide_done_in),
        .collide_addr_in(collide_addr_in), .stream_start_out(stream_start_out),
        .stream_done_in(stream_done_in), .stream_addr_in(stream_addr_in),
        .video_addr_in(video_addr_in), .video_grant_out(video_grant_out),
        .addr_out(addr_out), .owner_out(owner_out), .step_count_out(step_count_out),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Planned frame timeline (absolute cycle numbers).
    int cs[$], cd[$], ss[$], sd[$];
    int lat_c[$], lat_s[$];   // ack latency per pass, 0 = never acknowledged
    int t0, t_done;
    bit hung;
    bit err_before = 1'b0;
    int cnt_before = 0;

    // Previous-cycle stimulus and planned owner, for the addr_out latency check.
    int            prev_owner = -1;
    logic [LW-1:0] prev_c, prev_s;
    logic [BW-1:0] prev_v;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expected);
        n_checks++;
        if (obs !== expected) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    function automatic logic [LW-1:0] rand_lanes();
        logic [LW-1:0] r;
        for (int i = 0; i < 9; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    function automatic logic [LW-1:0] lanes_for(input int own, input logic [LW-1:0] c,
                                                 input logic [LW-1:0] s, input logic [BW-1:0] v);
        if (own == 1) return c;
        if (own == 2) return s;
        return {{(LW-BW){1'b0}}, v};
    endfunction

    // which: 0 collide starts, 1 collide acks, 2 stream starts, 3 stream acks
    function automatic bit hit(input int which, input int c);
        case (which)
            0: foreach (cs[i]) if (cs[i] == c) return 1'b1;
            1: foreach (cd[i]) if (cd[i] == c) return 1'b1;
            2: foreach (ss[i]) if (ss[i] == c) return 1'b1;
            default: foreach (sd[i]) if (sd[i] == c) return 1'b1;
        endcase
        return 1'b0;
    endfunction

    // Cycles in which a pass is waiting for its acknowledge.
    function automatic bit in_cwait(input int c);
        for (int i = 0; i < cs.size(); i++) begin
            int hi = (i < cd.size()) ? cd[i] : t_done - 1;
            if (c > cs[i] && c <= hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit in_swait(input int c);
        for (int i = 0; i < ss.size(); i++) begin
            int hi = (i < sd.size()) ? sd[i] : t_done - 1;
            if (c > ss[i] && c <= hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Planned bus owner; -1 where the frame rules leave it open (frame end).
    function automatic int exp_owner(input int c);
        if (c <= t0 || c > t_done) return 0;
        for (int i = 0; i < cs.size(); i++) begin
            int hi = (i < cd.size()) ? cd[i] : t_done - 1;
            if (c >= cs[i] && c <= hi) return 1;
        end
        for (int i = 0; i < ss.size(); i++) begin
            int hi = (i < sd.size()) ? sd[i] : t_done - 1;
            if (c >= ss[i] && c <= hi) return 2;
        end
        return -1;
    endfunction

    function automatic int exp_count(input int c);
        int n = 0;
        if (c <= t0) return cnt_before;
        foreach (sd[i]) if (sd[i] + 1 <= c) n++;
        return n;
    endfunction

    task automatic fill_lat(input int steps, input int hang_pct);
        lat_c.delete();
        lat_s.delete();
        for (int i = 0; i < steps; i++) begin
            lat_c.push_back(($urandom_range(99) < hang_pct) ? 0 :
                            ($urandom_range(5) == 0) ? TMO : $urandom_range(1, TMO));
            lat_s.push_back(($urandom_range(99) < hang_pct) ? 0 :
                            ($urandom_range(5) == 0) ? TMO : $urandom_range(1, TMO));
        end
    endtask

    task automatic run_frame(input int steps);
        int cur;
        int own;
        cs.delete(); cd.delete(); ss.delete(); sd.delete();
        t0   = cyc;
        hung = 1'b0;
        cur  = t0 + 1;
        for (int i = 0; i < steps; i++) begin
            cs.push_back(cur);
            if (lat_c[i] == 0) begin hung = 1'b1; break; end
            cd.push_back(cur + lat_c[i]);
            cur = cur + lat_c[i] + 1;
            ss.push_back(cur);
            if (lat_s[i] == 0) begin hung = 1'b1; break; end
            sd.push_back(cur + lat_s[i]);
            cur = cur + lat_s[i] + 1;
        end
        if (hung)            t_done = cur + TMO + 1;
        else if (steps == 0) t_done = t0 + 2;
        else                 t_done = cur;

        for (int c = t0; c <= t_done + 2; c++) begin
            start_in        = (c == t0) || (c > t0 && c <= t_done && $urandom_range(7) == 0);
            steps_in        = (c == t0) ? 8'(steps) : 8'($urandom);
            collide_done_in = hit(1, c) || (!in_cwait(c) && $urandom_range(5) == 0);
            stream_done_in  = hit(3, c) || (!in_swait(c) && $urandom_range(5) == 0);
            collide_addr_in = rand_lanes();
            stream_addr_in  = rand_lanes();
            video_addr_in   = BW'($urandom);

            @(negedge clk_in);
            check("collide_start", collide_start_out, hit(0, c));
            check("stream_start", stream_start_out, hit(2, c));
            check("done", done_out, c == t_done);
            check("busy", busy_out, c > t0 && c < t_done);
            check("grant", video_grant_out, c <= t0 || c > t_done);
            check("error", error_out, (c <= t0) ? err_before : (hung && c >= t_done));
            check("step_count", step_count_out, exp_count(c));
            own = exp_owner(c);
            if (own >= 0) check("owner", owner_out, own);
            if (prev_owner >= 0)
                check("addr", addr_out, lanes_for(prev_owner, prev_c, prev_s, prev_v));

            prev_owner = own;
            prev_c     = collide_addr_in;
            prev_s     = stream_addr_in;
            prev_v     = video_addr_in;
            next_cycle();
        end
        err_before = hung;
        cnt_before = sd.size();
    endtask

    task automatic reset_mid_frame();
        collide_done_in = 1'b0;
        stream_done_in  = 1'b0;
        start_in = 1'b1;
        steps_in = 8'd5;
        next_cycle();
        start_in = 1'b0;
        @(negedge clk_in);
        check("rm_collide_start", collide_start_out, 1'b1);
        next_cycle();
        collide_done_in = 1'b1;
        next_cycle();
        collide_done_in = 1'b0;
        @(negedge clk_in);
        check("rm_stream_start", stream_start_out, 1'b1);
        next_cycle();
        @(negedge clk_in);
        check("rm_owner_swait", owner_out, 2'd2);
        check("rm_busy_swait", busy_out, 1'b1);
        rst_in = 1'b1;
        next_cycle();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rm_state_busy", busy_out, 1'b0);
        check("rm_grant", video_grant_out, 1'b1);
        check("rm_owner", owner_out, 2'd0);
        check("rm_addr", addr_out, '0);
        check("rm_count", step_count_out, 8'd0);
        check("rm_error", error_out, 1'b0);
        check("rm_pulses", {collide_start_out, stream_start_out, done_out}, 3'b000);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk_in);
            check("rm_quiet_pulses", {collide_start_out, stream_start_out, done_out}, 3'b000);
            check("rm_quiet_busy", busy_out, 1'b0);
            check("rm_quiet_grant", video_grant_out, 1'b1);
        end
        next_cycle();
        prev_owner = -1;
        err_before = 1'b0;
        cnt_before = 0;
    endtask

    initial begin
        rst_in          = 1'b1;
        start_in        = 1'b0;
        steps_in        = 8'd0;
        collide_done_in = 1'b0;
        stream_done_in  = 1'b0;
        collide_addr_in = rand_lanes();
        stream_addr_in  = rand_lanes();
        video_addr_in   = BW'(16'h1234);
        repeat (3) next_cycle();

        @(negedge clk_in);
        check("rst_addr", addr_out, '0);
        check("rst_owner", owner_out, 2'd0);
        check("rst_grant", video_grant_out, 1'b1);
        check("rst_collide_start", collide_start_out, 1'b0);
        check("rst_stream_start", stream_start_out, 1'b0);
        check("rst_count", step_count_out, 8'd0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_error", error_out, 1'b0);
        rst_in = 1'b0;
        next_cycle();
        @(negedge clk_in);
        check("idle_video_lane0", addr_out, {{(LW-BW){1'b0}}, BW'(16'h1234)});
        check("idle_owner", owner_out, 2'd0);
        prev_owner = 0;
        prev_c     = collide_addr_in;
        prev_s     = stream_addr_in;
        prev_v     = video_addr_in;
        next_cycle();

        // Three steps, every pass acknowledged 10 cycles after its start.
        lat_c = '{10, 10, 10};
        lat_s = '{10, 10, 10};
        run_frame(3);
        // Empty frame.
        run_frame(0);
        // Acknowledge lands exactly in the watchdog expiry cycle.
        lat_c = '{TMO, 7};
        lat_s = '{3, TMO};
        run_frame(2);
        // Stream pass of the second step never acknowledges.
        lat_c = '{5, 5};
        lat_s = '{7, 0};
        run_frame(2);
        // Next start clears the sticky error.
        lat_c = '{4};
        lat_s = '{3};
        run_frame(1);
        // Collision pass of the second step never acknowledges.
        lat_c = '{3, 0, 2};
        lat_s = '{2, 2, 2};
        run_frame(3);

        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(4);
            fill_lat(n, 6);
            run_frame(n);
        end

        reset_mid_frame();
        fill_lat(2, 0);
        run_frame(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout cycle=%0d got=running want=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/lbm_step_sequencer.md
# lbm_step_sequencer

Top-level scheduler for the lattice-Boltzmann update loop. It runs a programmed number of timesteps; each timestep is one collision pass followed by one streaming pass. It owns the 9-lane BRAM address bus and steers it to the active pass, or to the video reader when idle. It also enforces a per-pass watchdog and reports step progress.

## Interface
Parameters:
- HPIXELS, 205, lattice width in cells
- VPIXELS, 154, lattice height in cells
- TIMEOUT, 100000, max cycles a pass may run before it is declared hung
- BRAM_SIZE (localparam), $clog2(HPIXELS*VPIXELS), address width

Ports:
- clk_in  input  1  system clock; all logic on posedge
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle request to run a frame; honored only in IDLE
- steps_in  input  8  timesteps per frame; latched when start_in is accepted
- collide_start_out  output  1  one-cycle start pulse to the collision pass
- collide_done_in  input  1  one-cycle completion pulse from the collision pass
- collide_addr_in  input  9×BRAM_SIZE  collision pass address lanes
- stream_start_out  output  1  one-cycle start pulse to the streaming pass
- stream_done_in  input  1  one-cycle completion pulse from the streaming pass
- stream_addr_in  input  9×BRAM_SIZE  streaming pass address lanes
- video_addr_in  input  BRAM_SIZE  video read address; driven onto lane 0 when granted
- video_grant_out  output  1  high while the video reader owns the bus
- addr_out  output  9×BRAM_SIZE  registered, muxed BRAM address lanes
- owner_out  output  2  bus owner: 0 video, 1 collide, 2 stream
- step_count_out  output  8  timesteps completed in the current or last frame
- busy_out  output  1  high from start acceptance until frame end
- done_out  output  1  one-cycle frame-complete pulse
- error_out  output  1  sticky watchdog flag; cleared by reset or an accepted start

## Operation
- States: IDLE, C_START, C_WAIT, S_START, S_WAIT, FINISH.
- IDLE:
  - owner 0, video_grant_out=1, busy_out=0.
  - When start_in is sampled: latch steps_in, clear step_count and error_out, set busy.
  - If the latched steps is 0, go to FINISH; otherwise go to C_START.
- C_START: collide_start_out=1 for this cycle only; owner 1; clear the watchdog; go to C_WAIT.
- C_WAIT:
  - owner 1.
  - collide_done_in goes to S_START.
  - Watchdog reaching TIMEOUT sets error_out and goes to FINISH.
- S_START: stream_start_out=1 for one cycle; owner 2; clear the watchdog; go to S_WAIT.
- S_WAIT:
  - owner 2.
  - stream_done_in increments step_count (8-bit, no wrap possible because steps ≤ 255).
  - If the new count equals steps, go to FINISH; otherwise go to C_START.
  - Watchdog timeout is handled as in C_WAIT.
- FINISH: done_out=1 for one cycle, busy_out=0, go to IDLE. step_count_out holds its value until the next accepted start.
- Done inputs are ignored in every state except their own WAIT state. A stray pulse has no effect.
- start_in while busy is ignored; it is not queued.
- Bus mux:
  - owner 0: lane 0 = video_addr_in, lanes 1–8 = 0.
  - owner 1: lanes = collide_addr_in.
  - owner 2: lanes = stream_addr_in.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1); it increments each cycle in a WAIT state.
  - A timeout fires when the counter equals TIMEOUT-1 and no done pulse is present that cycle.
  - If done and timeout coincide, done wins.

## Timing
- Reset values: state IDLE, addr_out 0, owner_out 0, video_grant_out 1, collide_start_out 0, stream_start_out 0, step_count_out 0, busy_out 0, done_out 0, error_out 0.
- Reset mid-frame aborts immediately. No start or done pulse is emitted after reset.
- All outputs are registered.
- addr_out reflects the inputs of the previous cycle under the owner selected in the previous cycle (1-cycle latency).
- owner_out and video_grant_out change in the same cycle as the state register.
- start_in sampled in cycle t:
  - busy_out=1 and collide_start_out=1 at t+1.
  - video_grant_out=0 at t+1.
- collide_done_in sampled at k: stream_start_out=1 at k+1.
- stream_done_in sampled at m, more steps remaining: collide_start_out=1 at m+1.
- stream_done_in sampled at m, final step: done_out=1 at m+1, then IDLE and video grant at m+2.
- Minimum per-step overhead: 2 cycles (the two START states).
- steps=0: done_out at t+2 with no pass pulses.

## Test plan
- Reset, then idle: all outputs at their reset values; video_addr_in=0x1234 appears on addr_out lane 0 one cycle later; owner_out=0.
- steps_in=3, each pass acknowledged 10 cycles after its start: 3 collide and 3 stream pulses strictly alternating; step_count_out 1,2,3; single done_out; busy_out high throughout.
- steps_in=0: done_out at t+2, no start pulses, step_count_out=0.
- TIMEOUT=50, stream_done_in never asserted: error_out=1 and done_out pulse 50 cycles after entering S_WAIT; a subsequent start clears error_out.
- Stray pulses:
  - stream_done_in during C_WAIT: ignored.
  - start_in during a frame: ignored.
  - done and timeout in the same cycle: no error.
- Mux check: distinct patterns on collide and stream lanes; addr_out matches the owner's lanes with 1-cycle lag at each handover; reset asserted mid S_WAIT returns to IDLE the next cycle.
